// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; optional MDU_EARLY_OUT_EN.
// Ports: clk, reset (async, active-high); start/op/a/b issue an op; cancel aborts it;
// hi_we/lo_we/wdata are MTHI/MTLO; busy, done pulse, sticky div_zero; hi/lo always readable.
module mdu_iterative #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
  logic [WIDTH-1:0] md_q, md_d, hi_q, hi_d, lo_q, lo_d, ma, mb, q_fix, r_fix, diff;
  logic [WIDTH:0] sum, r_sh;
  logic neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, dz_q, dz_d;
  logic done_q, done_d, div_zero_q, div_zero_d, sa, sb, ge;
  assign sa = op[0] & a[WIDTH-1];
  assign sb = op[0] & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};
  // Restoring divide: the shifted partial remainder needs one extra bit before the compare
  assign r_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge = r_sh >= {1'b0, md_q};
  assign diff = r_sh[WIDTH-1:0] - md_q;
  assign step = div_q ? (ge ? {diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0})
                      : (acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]});
  assign prod = neg_q ? -acc_q : acc_q;
  assign q_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    md_d = md_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    div_d = div_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_zero_d = div_zero_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        hi_d = hi_we ? wdata : hi_q;
        lo_d = lo_we ? wdata : lo_q;
        if (start) begin
          div_d = op[1];
          neg_d = sa ^ sb;
          rneg_d = sa;
          cnt_d = CNT_W'(WIDTH);
          md_d = op[1] ? mb : ma;
          dz_d = op[1] && b == '0;
          // Divide by zero bypasses CALC with the architectural result preloaded
          acc_d = dz_d ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op[1] ? ma : mb};
          state_d = dz_d ? FIX : CALC;
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q - CNT_W'(1);
        state_d = cnt_d == '0 ? FIX : CALC;
`ifdef MDU_EARLY_OUT_EN
        // Remaining multiplier bits all zero: the rest of the steps would only shift
        if (!div_q && cnt_d != '0 && (step[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt_d)) == '0) begin
          acc_d = step >> cnt_d;
          cnt_d = '0;
          state_d = FIX;
        end
`endif
        if (cancel) state_d = IDLE;
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          hi_d = dz_q ? acc_q[2*WIDTH-1:WIDTH] : div_q ? r_fix : prod[2*WIDTH-1:WIDTH];
          lo_d = dz_q ? acc_q[WIDTH-1:0] : div_q ? q_fix : prod[WIDTH-1:0];
          div_zero_d = div_q ? dz_q : div_zero_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      md_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      div_zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      md_q <= md_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      div_q <= div_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_zero_q <= div_zero_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign div_zero = div_zero_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: scoreboard bench for mdu_iterative (results, latency, busy, cancel, reset).
module tb_mdu_iterative;
  logic clk = 0, reset = 1, start = 0, cancel = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int tests = 0, fails = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic m_dz = 0;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic dz;
    int lat;
  } exp_t;
  exp_t sb_q[$];
  mdu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sx, sy, sq, sr;
    logic [31:0] mb;
    int steps;
    e.dz = m_dz;
    e.lat = 34;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (o[1] && y == 0) begin
      e.hi = x;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1;
      e.lat = 2;
    end else if (o == 2'd0) begin
      p = {32'b0, x} * {32'b0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == 2'd1) begin
      p = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == 2'd2) begin
      e.lo = x / y;
      e.hi = x % y;
      e.dz = 0;
    end else begin
      sq = sx / sy;
      sr = sx % sy;
      e.lo = sq[31:0];
      e.hi = sr[31:0];
      e.dz = 0;
    end
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) begin
      mb = (o[0] && y[31]) ? -y : y;
      steps = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) steps = i + 1;
      e.lat = steps + 2;
    end
`endif
    return e;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit meddle);
    exp_t e;
    int lat, bcnt;
    sb_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 0;
    lat = 0;
    bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      start = meddle && lat == 2;
      lo_we = meddle && lat == 2;
      wdata = 32'hDEAD_BEEF;
      if (done) break;
    end
    start = 0;
    lo_we = 0;
    e = sb_q.pop_front();
    if (lat >= 100) check("timeout", 0, 1);
    check("hi", hi, e.hi);
    check("lo", lo, e.lo);
    check("div_zero", div_zero, e.dz);
    check("latency", lat, e.lat);
    check("busy_cycles", bcnt, e.lat - 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    m_hi = e.hi;
    m_lo = e.lo;
    m_dz = e.dz;
  endtask
  initial begin
    bit seen;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    reset = 0;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd1, -32'sd3, 32'd7, 0);
    run_op(2'd1, 32'd5, 32'd1, 0);
    run_op(2'd3, -32'sd7, 32'd2, 0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'd100, 32'd0, 0);
    run_op(2'd0, 32'd3, 32'd0, 0);
    run_op(2'd2, 32'd9, 32'd4, 0);
    run_op(2'd3, -32'sd5, 32'd0, 0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      if (i % 3 == 0) rb = -rb;
      run_op(ro, ra, rb, 0);
    end
    @(negedge clk);
    hi_we = 1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 0;
    check("mthi", hi, 32'h1234);
    check("mthi_lo_kept", lo, m_lo);
    run_op(2'd0, 32'd6, 32'd7, 1);
    @(negedge clk);
    start = 1; op = 2'd3; a = 32'd50; b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= done;
    end
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cancel_busy", busy, 0);
    seen |= done;
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    check("cancel_no_done", seen, 0);
    check("cancel_hi", hi, m_hi);
    check("cancel_lo", lo, m_lo);
    check("cancel_busy_idle", busy, 0);
    start = 1; op = 2'd3; a = 32'd50; b = 32'd0;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    start = 1; op = 2'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    check("midcalc_busy", busy, 1);
    reset = 1;
    #1;
    check("async_hi", hi, 0);
    check("async_lo", lo, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_dz", div_zero, 0);
    @(negedge clk);
    reset = 0;
    m_hi = 0; m_lo = 0; m_dz = 0;
    run_op(2'd2, 32'd50, 32'd3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit for the MIPS core, adding MULT, MULTU, DIV and DIVU plus the HI/LO architectural registers.
- Sits beside the single-cycle ALU. The controller issues an operation with a start pulse and stalls on busy.
- Radix-2, one bit per cycle, parametrised in operand width.
- HI/LO are readable at all times, so MFHI/MFLO are simple mux reads.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  issue an operation; sampled only in IDLE.
- op  input  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand / dividend (rs).
- b  input  WIDTH  multiplier / divisor (rt).
- cancel  input  1  abort the in-flight operation.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO receive a result.
- div_zero  output  1  sticky flag: last divide had b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- **Reset values:** hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE. Reset is asynchronous and takes effect mid-operation; partial results are discarded.
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - start=1 at edge k latches the magnitudes of a and b (signed ops only: two's-complement negate when MSB=1), the result signs and op. Counter is set to WIDTH.
  - Go to CALC; busy=1 from k+1.
  - If a divide has b==0, go straight to FIX and skip CALC.
- **CALC, multiply:** shift-add over a 2*WIDTH accumulator.
- **CALC, divide:** restoring shift-subtract.
- **CALC, each cycle:** counter decrements by 1. When it reaches 0, go to FIX. This takes exactly WIDTH cycles.
- **FIX:**
  - Apply sign correction. Product is negated if sign(a)^sign(b). Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a.
  - On exit from FIX, write hi/lo: hi=product[2W-1:W] or remainder; lo=product[W-1:0] or quotient.
  - done=1 for that following cycle, busy=0, return to IDLE.
- **Latency:**
  - Start at edge k gives the hi/lo update and done at edge k+WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero completes at k+2.
- **Divide by zero:** lo=all ones, hi=a (raw operand), div_zero=1. div_zero is cleared by the next divide that has b!=0. No exception is raised.
- **Signed overflow (DIV 0x80..0 / -1):** lo=0x80..0, hi=0. This falls out of the magnitude algorithm and must not be special-cased incorrectly.
- **start while busy:** ignored; no queueing. The controller must hold the instruction until busy=0.
- **cancel while busy:** next state IDLE, busy=0 next cycle, no done, hi/lo unchanged. cancel in IDLE has no effect.
- **cancel and FIX exit in the same cycle:** cancel wins; hi/lo are not updated.
- **hi_we/lo_we:**
  - Honoured only when busy=0; they write hi/lo at the edge.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, the write happens and the operation also starts. The operation's result later overwrites the write.
  - While busy, hi_we/lo_we are ignored.
- **done vs. hi/lo update:** done is never asserted in the same cycle as an hi_we/lo_we update.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- **Defined (multiply ops only):** in CALC, if the remaining unshifted multiplier bits are all zero, go to FIX immediately. The accumulator is aligned with a single final shift by the remaining count, so the result is identical. Minimum multiply latency is 3 cycles (b==0 or b==1 after magnitude). Divide latency is unchanged.
- **Undefined:** fixed WIDTH-cycle CALC for all ops; the early-out logic is not synthesised.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE lo=0x00000001, done exactly 34 cycles after start, busy high for 33 cycles. With MDU_EARLY_OUT_EN the latency is still 34.
- MULT a=-3 b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB. With MDU_EARLY_OUT_EN and a=5 b=1 → hi=0 lo=5, done 3 cycles after start.
- DIV a=-7 b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF. Then DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0.
- DIVU a=100 b=0 → lo=0xFFFFFFFF hi=0x64, div_zero=1, done 2 cycles after start. Next DIVU 9/4 → lo=2 hi=1, div_zero=0.
- hi_we wdata=0x1234 in IDLE → hi=0x1234. Then start MULTU 6*7; during busy, lo_we=1 and a second start are both ignored; final lo=42 hi=0.
- Start DIV 50/3, cancel at cycle 10 → busy=0 next cycle, no done, hi/lo keep prior values. Repeat with reset asserted mid-CALC → all outputs 0 asynchronously.
